// File: rtl/fifo_256_pkg.sv
// rtl/fifo_256_pkg.sv - shared sizing constants and lane-select helper for the banked word FIFO
package fifo_256_pkg;

  localparam int WORD_W = 16;
  localparam int LANES  = 16;
  localparam int DEPTH  = 256;
  localparam int LANE_W = $clog2(LANES);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ROWS   = DEPTH / LANES;
  localparam int ROW_W  = PTR_W - LANE_W;

  // Input lane that lands in a given bank when the write starts at bank wr_lane.
  function automatic int lane_offset(input int bank, input int wr_lane, input int lanes);
    return (bank - wr_lane) & (lanes - 1);
  endfunction

endpackage

// File: rtl/fifo_256_bank.sv
// rtl/fifo_256_bank.sv - one storage bank: single write port, asynchronous read port
module fifo_256_bank #(
  parameter int WORD_W = fifo_256_pkg::WORD_W,
  parameter int ROWS   = fifo_256_pkg::ROWS
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    we,
  input  logic [$clog2(ROWS)-1:0] waddr,
  input  logic [WORD_W-1:0]       wdata,
  input  logic [$clog2(ROWS)-1:0] raddr,
  output logic [WORD_W-1:0]       rdata
);

  logic [WORD_W-1:0] mem_q [ROWS];

  // Cleared on reset so the show-ahead output never reads X.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < ROWS; r++) mem_q[r] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_256.sv
// rtl/fifo_256.sv - multi-word-write, single-word-read FIFO built from LANES interleaved banks
module fifo_256 #(
  parameter int WORD_W = fifo_256_pkg::WORD_W,
  parameter int LANES  = fifo_256_pkg::LANES,
  parameter int DEPTH  = fifo_256_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [LANES*WORD_W-1:0]  data_i,
  input  logic [$clog2(LANES)-1:0] size_i,
  input  logic                     data_we,
  output logic [WORD_W-1:0]        data_o,
  input  logic                     data_rd,
  output logic                     full,
  output logic                     empty
);
  import fifo_256_pkg::*;

  localparam int LW = $clog2(LANES);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NR = DEPTH / LANES;
  localparam int RW = PW - LW;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic [LW:0]       size_eff;
  logic              wr_acc, rd_acc;
  logic [LANES-1:0]  bank_we;
  logic [LW-1:0]     bank_off   [LANES];
  logic [RW-1:0]     bank_wrow  [LANES];
  logic [WORD_W-1:0] bank_wdata [LANES];
  logic [WORD_W-1:0] bank_rdata [LANES];

  always_comb begin
    size_eff = (size_i == '0) ? (LW+1)'(LANES) : {1'b0, size_i};
    wr_acc   = data_we && !full_q;
    rd_acc   = data_rd && !empty_q;
    // Each bank picks its lane; banks below the start lane take the next row.
    for (int b = 0; b < LANES; b++) begin
      bank_off[b]   = LW'(lane_offset(b, int'(wr_ptr_q[LW-1:0]), LANES));
      bank_we[b]    = wr_acc && ({1'b0, bank_off[b]} < size_eff);
      bank_wrow[b]  = RW'((wr_ptr_q + PW'(bank_off[b])) >> LW);
      bank_wdata[b] = data_i[bank_off[b]*WORD_W +: WORD_W];
    end
    wr_ptr_d = wr_acc ? wr_ptr_q + PW'(size_eff) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + (wr_acc ? CW'(size_eff) : CW'(0)) - (rd_acc ? CW'(1) : CW'(0));
    full_d   = count_d > CW'(DEPTH - LANES);
    empty_d  = count_d == '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  for (genvar b = 0; b < LANES; b++) begin : g_bank
    fifo_256_bank #(
      .WORD_W (WORD_W),
      .ROWS   (NR)
    ) u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (bank_we[b]),
      .waddr   (bank_wrow[b]),
      .wdata   (bank_wdata[b]),
      .raddr   (rd_ptr_q[PW-1:LW]),
      .rdata   (bank_rdata[b])
    );
  end

  assign data_o = bank_rdata[rd_ptr_q[LW-1:0]];
  assign full   = full_q;
  assign empty  = empty_q;

endmodule

// File: tb/tb_fifo_256.sv
// tb/tb_fifo_256.sv - directed scoreboard bench for the banked word FIFO
module tb_fifo_256;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [255:0] data_i = '0;
  logic [3:0]   size_i = '0;
  logic         data_we = 1'b0;
  logic         data_rd = 1'b0;
  logic [15:0]  data_o;
  logic         full;
  logic         empty;

  int          n_cmp = 0;
  int          n_err = 0;
  int          next_word = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  fifo_256 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .data_i  (data_i),
    .size_i  (size_i),
    .data_we (data_we),
    .data_o  (data_o),
    .data_rd (data_rd),
    .full    (full),
    .empty   (empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    chk("empty", 32'(empty), 32'(exp_q.size() == 0));
    chk("full", 32'(full), 32'(exp_q.size() > 240));
    if (exp_q.size() > 0) chk("data_o", 32'(data_o), 32'(exp_q[0]));
  endtask

  // One clock: check outputs, drive a write of sz words and/or a pop, update the model.
  task automatic cycle(input bit we, input int sz, input bit rd);
    logic [4:0] s5;
    bit         wacc;
    check_outputs();
    s5      = 5'(sz);
    data_we = we;
    data_rd = rd;
    size_i  = s5[3:0];
    for (int j = 0; j < 16; j++) data_i[j*16 +: 16] = 16'(next_word + j);
    wacc = we && !(exp_q.size() > 240);
    if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
    if (wacc) for (int j = 0; j < sz; j++) exp_q.push_back(16'(next_word + j));
    if (we) next_word += sz;
    @(posedge clk);
    #1;
    data_we = 1'b0;
    data_rd = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) cycle(1'b0, 1, 1'b1);
    cycle(1'b0, 1, 1'b0);
  endtask

  task automatic async_reset();
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_data_o", 32'(data_o), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("init_empty", 32'(empty), 32'd1);
    chk("init_full", 32'(full), 32'd0);
    chk("init_data_o", 32'(data_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // 20 writes of sizes 3..16,1..6, then a pop every other cycle
    next_word = 16'h0A00;
    for (int i = 0; i < 20; i++) cycle(1'b1, ((i + 2) % 16) + 1, 1'b0);
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin
      cycle(1'b0, 1, 1'b1);
      cycle(1'b0, 1, 1'b0);
    end
    chk("seq_done_empty", 32'(empty), 32'd1);

    // single full-width write into an empty FIFO
    next_word = 16'h1000;
    cycle(1'b1, 16, 1'b0);
    chk("w16_empty", 32'(empty), 32'd0);
    chk("w16_lane0", 32'(data_o), 32'h1000);
    drain();

    // fill to 240, cross into full, drop a write while full
    next_word = 16'h2000;
    for (int i = 0; i < 15; i++) cycle(1'b1, 16, 1'b0);
    chk("fill240_full", 32'(full), 32'd0);
    cycle(1'b1, 1, 1'b0);
    chk("fill241_full", 32'(full), 32'd1);
    cycle(1'b1, 16, 1'b0);
    chk("fill_drop_full", 32'(full), 32'd1);
    drain();

    // simultaneous write of 5 and read each cycle
    next_word = 16'h3000;
    cycle(1'b1, 8, 1'b0);
    cycle(1'b1, 8, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 5, 1'b1);
    drain();

    // mixed random-size writes with continuous reads, many pointer wraps
    next_word = 16'h4000;
    for (int i = 0; i < 150; i++) cycle(i % 3 == 0, int'($urandom_range(1, 16)), 1'b1);
    drain();

    // reset while non-empty, then new data must come out first
    next_word = 16'h5000;
    for (int i = 0; i < 3; i++) cycle(1'b1, 16, 1'b0);
    async_reset();
    next_word = 16'h6000;
    cycle(1'b1, 5, 1'b0);
    chk("post_rst_head", 32'(data_o), 32'h6000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
